uart_rx_fifo: RTL

Receive buffer directly downstream of the UART receiver, in the parallel (pclk_i) domain. It accepts 10-bit raw frames on a write strobe and checks framing (start and stop bits). It stores the data byte plus a per-entry error flag in a circular buffer, and presents entries to the host through a first-word-fall-through read interface. It also keeps a sticky overflow flag and a saturating framing-error counter for status registers.

---
 rtl/uart_rx_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: checks frame bits and queues data plus an error flag.
// Presents the head entry first-word-fall-through, with a sticky overflow flag and a framing-error count.
module uart_rx_fifo #(
    parameter int ADDR_W   = 4,
    parameter bit DROP_BAD = 1'b0
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    input  logic              winc_i,
    input  logic [9:0]        wdata_i,
    input  logic              rinc_i,
    input  logic              clr_i,
    output logic [7:0]        rdata_o,
    output logic              rferr_o,
    output logic              rempty_o,
    output logic              wfull_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic [7:0]        err_cnt_o
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

    // A frame is bad when the start bit is not 0 or the stop bit is not 1.
    function automatic logic frame_bad(input logic [9:0] frame);
        return (frame[0] != 1'b0) || (frame[9] != 1'b1);
    endfunction

    logic [8:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic [7:0]        r_err_cnt;

    logic              w_bad;
    logic              w_keep;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf;
    logic [8:0]        w_head;

    // Store/pop/overflow decisions for the current cycle.
    always_comb begin
        w_bad   = frame_bad(wdata_i);
        w_keep  = winc_i && !(DROP_BAD && w_bad);
        w_empty = (r_count == {(ADDR_W+1){1'b0}});
        w_full  = (r_count == DEPTH_CNT);
        w_pop   = rinc_i && !w_empty;
        // A pop in the same cycle frees the slot, so a full buffer still accepts.
        w_push  = w_keep && (!w_full || w_pop);
        w_ovf   = w_keep && w_full && !w_pop;
    end

    // Output flags and FWFT head, gated to zero when empty.
    always_comb begin
        w_head     = r_mem[r_rptr];
        rempty_o   = w_empty;
        wfull_o    = w_full;
        count_o    = r_count;
        overflow_o = r_overflow;
        err_cnt_o  = r_err_cnt;
        if (w_empty) begin
            rdata_o = 8'h00;
            rferr_o = 1'b0;
        end else begin
            rdata_o = w_head[7:0];
            rferr_o = w_head[8];
        end
    end

    // Entry storage; contents are not reset.
    always_ff @(posedge pclk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_bad, wdata_i[8:1]};
        end
    end

    // Pointers, occupancy count and status registers.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_wptr     <= {ADDR_W{1'b0}};
            r_rptr     <= {ADDR_W{1'b0}};
            r_count    <= {(ADDR_W+1){1'b0}};
            r_overflow <= 1'b0;
            r_err_cnt  <= 8'h00;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            // A new event in the same cycle as clr_i takes priority over the clear.
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end else if (clr_i) begin
                r_overflow <= 1'b0;
            end
            if (winc_i && w_bad) begin
                if (clr_i) begin
                    r_err_cnt <= 8'h01;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'h01;
                end
            end else if (clr_i) begin
                r_err_cnt <= 8'h00;
            end
        end
    end

    uart_rx_fifo_chk #(.ADDR_W(ADDR_W)) u_chk (
        .clk_i    (pclk_i),
        .rst_i    (prst_i),
        .rempty_i (rempty_o),
        .wfull_i  (wfull_o),
        .count_i  (count_o)
    );

endmodule

// Structural invariants on the occupancy flags.
module uart_rx_fifo_chk #(
    parameter int ADDR_W = 4
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            rempty_i,
    input logic            wfull_i,
    input logic [ADDR_W:0] count_i
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(1 << ADDR_W);

    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count_i <= DEPTH_CNT);
    a_flags_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rempty_i && wfull_i));
    a_empty_match: assert property (@(posedge clk_i) disable iff (rst_i)
        rempty_i == (count_i == {(ADDR_W+1){1'b0}}));

endmodule
